// File: rtl/bram_read_arbiter.sv
// Round-robin arbiter sharing one BRAM read port between NUM_REQ requesters, with burst lock
// and per-requester read-valid tracking aligned to the fixed BRAM read latency.
module bram_read_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned ADDR_WIDTH   = 14,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,
    localparam int unsigned IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]            req_lock_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rd_valid_o,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    output logic [ADDR_WIDTH-1:0]         bram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0]         bram_rd_data_i,
    output logic [IDX_W-1:0]              owner_o,
    output logic                          locked_o,
    output logic [15:0]                   stall_count_o
);

    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic                    locked_q, locked_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]             stall_q, stall_d;
    logic [READ_LATENCY-1:0] pv_q;
    logic [IDX_W-1:0]        pi_q [READ_LATENCY];

    logic                    lock_hold;
    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W:0]          scan_sum;
    logic [IDX_W-1:0]        cand;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + IDX_W'(1);
    endfunction

    // The lock only holds in a cycle where the owner still asserts req_lock; otherwise this
    // cycle arbitrates normally and the lock is released at the edge.
    assign lock_hold = locked_q && req_lock_i[owner_q];

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        cand      = '0;
        if (lock_hold) begin
            if (req_i[owner_q]) begin
                win_found = 1'b1;
                win_idx   = owner_q;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
                if (scan_sum >= (IDX_W+1)'(NUM_REQ)) begin
                    scan_sum = scan_sum - (IDX_W+1)'(NUM_REQ);
                end
                cand = scan_sum[IDX_W-1:0];
                if (!win_found && req_i[cand]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        gnt_o          = '0;
        bram_rd_addr_o = addr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_found && win_idx == IDX_W'(i)) begin
                gnt_o[i]       = 1'b1;
                bram_rd_addr_o = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        locked_d = 1'b0;
        stall_d  = stall_q;
        if (win_found) begin
            owner_d = win_idx;
            addr_d  = bram_rd_addr_o;
        end
        if (win_found && !lock_hold) begin
            ptr_d = next_idx(win_idx);
        end else if (locked_q && !lock_hold) begin
            ptr_d = next_idx(owner_q);
        end
        if (lock_hold) begin
            locked_d = 1'b1;
        end else if (win_found) begin
            locked_d = req_lock_i[win_idx];
        end
        if (|(req_i & ~gnt_o) && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q    <= '0;
            owner_q  <= '0;
            locked_q <= 1'b0;
            addr_q   <= '0;
            stall_q  <= '0;
            pv_q     <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pi_q[i] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            locked_q <= locked_d;
            addr_q   <= addr_d;
            stall_q  <= stall_d;
            pv_q[0]  <= win_found;
            pi_q[0]  <= win_idx;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pi_q[i] <= pi_q[i-1];
            end
        end
    end

    always_comb begin
        rd_valid_o = '0;
        if (pv_q[READ_LATENCY-1]) begin
            rd_valid_o[pi_q[READ_LATENCY-1]] = 1'b1;
        end
    end

    assign rd_data_o     = bram_rd_data_i;
    assign owner_o       = owner_q;
    assign locked_o      = locked_q;
    assign stall_count_o = stall_q;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Self-checking bench for bram_read_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based behavioural model of arbitration, locking and read returns.
module tb_bram_read_arbiter;

    localparam int N   = 3;
    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [N-1:0]      req, lock;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      gnt, rd_valid;
    logic [DW-1:0]     rd_data, bram_rd_data;
    logic [AW-1:0]     bram_rd_addr;
    logic [1:0]        owner;
    logic              locked;
    logic [15:0]       stall_count;

    int errors = 0;
    int checks = 0;

    bram_read_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .req_addr_i(req_addr), .req_lock_i(lock),
        .gnt_o(gnt), .rd_valid_o(rd_valid), .rd_data_o(rd_data), .bram_rd_addr_o(bram_rd_addr),
        .bram_rd_data_i(bram_rd_data), .owner_o(owner), .locked_o(locked),
        .stall_count_o(stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        return {a, 18'h0} ^ (32'h1234_5678 + 32'(a) * 32'd2654435761);
    endfunction

    // BRAM model: data for an address appears LAT cycles after it was presented.
    logic [AW-1:0] ahist [LAT];
    always @(posedge clk) begin
        ahist[0] <= bram_rd_addr;
        for (int i = 1; i < LAT; i++) ahist[i] <= ahist[i-1];
    end
    always_comb bram_rd_data = mem(ahist[LAT-1]);

    // Behavioural model
    typedef struct { int due; int idx; logic [AW-1:0] addr; } rd_t;
    rd_t pend[$];
    int m_ptr, m_owner, m_stall, cyc;
    bit m_locked;
    logic [AW-1:0] m_last;
    bit e_found, e_hold;
    int e_win;
    logic [N-1:0]  e_gnt, e_rdv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rdata;

    function automatic logic [AW-1:0] addr_of(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic void model_reset();
        m_ptr = 0; m_owner = 0; m_stall = 0; m_locked = 0; m_last = '0;
        pend.delete();
    endfunction

    function automatic void model_eval();
        int c;
        e_hold  = m_locked && lock[m_owner];
        e_found = 0;
        e_win   = 0;
        if (e_hold) begin
            if (req[m_owner]) begin e_found = 1; e_win = m_owner; end
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!e_found && req[c]) begin e_found = 1; e_win = c; end
            end
        end
        e_gnt  = e_found ? N'(1 << e_win) : '0;
        e_addr = e_found ? addr_of(e_win) : m_last;
        e_rdv  = '0;
        e_rdata = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e_rdv   = N'(1 << pend[0].idx);
            e_rdata = mem(pend[0].addr);
        end
    endfunction

    function automatic void model_update();
        int old_owner = m_owner;
        if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
        if (e_found) begin
            m_owner = e_win;
            m_last  = e_addr;
            pend.push_back('{due: cyc + LAT, idx: e_win, addr: e_addr});
        end
        if ((req & ~e_gnt) != 0 && m_stall < 65535) m_stall++;
        if (e_found && !e_hold) m_ptr = (e_win + 1) % N;
        else if (m_locked && !e_hold) m_ptr = (old_owner + 1) % N;
        m_locked = e_hold ? 1'b1 : (e_found && lock[e_win]);
        cyc++;
    endfunction

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_addr(input int a0, input int a1, input int a2);
        req_addr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; req = '0; lock = '0; set_addr(0, 0, 0);
        model_reset();
        cyc = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({gnt, rd_valid, bram_rd_addr, owner, locked, stall_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b rdv=%b addr=%0d own=%0d lk=%b st=%0d exp all 0",
                     gnt, rd_valid, bram_rd_addr, owner, locked, stall_count);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        settle();
        checks++;
        if (gnt !== '0 || bram_rd_addr !== '0) begin
            errors++;
            $display("FAIL reset_release got gnt=%b addr=%0d exp 0/0", gnt, bram_rd_addr);
        end
        advance();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] seq;
        req = 3'b111; lock = '0; set_addr(10, 20, 30);
        for (int c = 0; c < 6; c++) begin
            settle();
            seq = N'(1 << (c % 3));
            checks++;
            if (gnt !== seq || gnt !== e_gnt) begin
                errors++;
                $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, seq);
            end
            checks++;
            if (bram_rd_addr !== AW'(10 * (c % 3 + 1))) begin
                errors++;
                $display("FAIL rr_addr c=%0d got=%0d exp=%0d", c, bram_rd_addr, 10 * (c % 3 + 1));
            end
            checks++;
            if (rd_valid !== e_rdv) begin
                errors++;
                $display("FAIL rr_rdvalid c=%0d got=%b exp=%b", c, rd_valid, e_rdv);
            end
            advance();
        end
        req = '0;
        settle();
        checks++;
        if (stall_count !== 16'd6) begin
            errors++;
            $display("FAIL rr_stall got=%0d exp=6", stall_count);
        end
        for (int c = 0; c < LAT + 1; c++) begin
            if (c > 0) settle();
            checks++;
            if (rd_valid !== e_rdv || (e_rdv != 0 && rd_data !== e_rdata)) begin
                errors++;
                $display("FAIL rr_drain c=%0d got=%b/%h exp=%b/%h", c, rd_valid, rd_data, e_rdv, e_rdata);
            end
            advance();
        end
    endtask

    task automatic test_lock_burst();
        for (int c = 0; c < 5; c++) begin
            req  = (c == 0) ? 3'b010 : (c == 4 ? 3'b001 : 3'b011);
            lock = (c < 4) ? 3'b010 : 3'b000;
            set_addr(55, 100 + c, 0);
            settle();
            checks++;
            if (gnt !== e_gnt || gnt !== ((c < 4) ? 3'b010 : 3'b001)) begin
                errors++;
                $display("FAIL lock_gnt c=%0d got=%b exp=%b", c, gnt, e_gnt);
            end
            checks++;
            if (bram_rd_addr !== e_addr || (c < 4 && bram_rd_addr !== AW'(100 + c))) begin
                errors++;
                $display("FAIL lock_addr c=%0d got=%0d exp=%0d", c, bram_rd_addr, e_addr);
            end
            checks++;
            if (locked !== m_locked || (c > 0 && locked !== 1'b1)) begin
                errors++;
                $display("FAIL lock_flag c=%0d got=%b exp=%b", c, locked, m_locked);
            end
            advance();
        end
        req = '0; lock = '0;
        repeat (LAT + 1) begin settle(); advance(); end
    endtask

    task automatic test_owner_gap();
        logic [N-1:0] rq [5] = '{3'b010, 3'b100, 3'b100, 3'b110, 3'b100};
        logic [N-1:0] lk [5] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
        logic [N-1:0] eg [5] = '{3'b010, 3'b000, 3'b000, 3'b010, 3'b100};
        int           ea [5] = '{200, 200, 200, 201, 300};
        for (int c = 0; c < 5; c++) begin
            req = rq[c]; lock = lk[c];
            set_addr(0, (c < 3) ? 200 : 201, 300);
            settle();
            checks++;
            if (gnt !== eg[c] || gnt !== e_gnt) begin
                errors++;
                $display("FAIL gap_gnt c=%0d got=%b exp=%b", c, gnt, eg[c]);
            end
            checks++;
            if (bram_rd_addr !== AW'(ea[c])) begin
                errors++;
                $display("FAIL gap_addr c=%0d got=%0d exp=%0d", c, bram_rd_addr, ea[c]);
            end
            checks++;
            if (rd_valid !== e_rdv || owner !== 2'(m_owner)) begin
                errors++;
                $display("FAIL gap_state c=%0d got=%b/%0d exp=%b/%0d", c, rd_valid, owner, e_rdv, m_owner);
            end
            advance();
        end
        req = '0; lock = '0;
        repeat (LAT + 1) begin settle(); advance(); end
    endtask

    task automatic test_latency();
        req = 3'b001; lock = '0; set_addr(7, 0, 0);
        settle();
        advance();
        req = '0;
        for (int k = 1; k <= LAT + 1; k++) begin
            settle();
            checks++;
            if (rd_valid !== ((k == LAT) ? 3'b001 : 3'b000) || rd_valid !== e_rdv) begin
                errors++;
                $display("FAIL lat_rdvalid k=%0d got=%b exp=%b", k, rd_valid, e_rdv);
            end
            if (k == LAT) begin
                checks++;
                if (rd_data !== mem(14'd7)) begin
                    errors++;
                    $display("FAIL lat_rdata got=%h exp=%h", rd_data, mem(14'd7));
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_midop();
        req = 3'b011; lock = '0; set_addr(40, 41, 0);
        repeat (2) begin settle(); advance(); end
        req = '0;
        rst_ni = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({gnt, rd_valid, bram_rd_addr, owner, locked, stall_count} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got gnt=%b rdv=%b addr=%0d own=%0d lk=%b st=%0d exp 0",
                     gnt, rd_valid, bram_rd_addr, owner, locked, stall_count);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        for (int c = 0; c < LAT + 1; c++) begin
            settle();
            checks++;
            if (rd_valid !== 3'b000 || bram_rd_addr !== '0) begin
                errors++;
                $display("FAIL midrst_flush c=%0d got=%b/%0d exp=000/0", c, rd_valid, bram_rd_addr);
            end
            advance();
        end
        req = 3'b111; set_addr(1, 2, 3);
        settle();
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL midrst_ptr got=%b exp=001", gnt);
        end
        advance();
        req = '0;
        repeat (LAT + 1) begin settle(); advance(); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req  = N'($urandom);
            lock = '0;
            for (int i = 0; i < N; i++) lock[i] = ($urandom_range(0, 3) == 0);
            set_addr($urandom, $urandom, $urandom);
            settle();
            checks++;
            if (gnt !== e_gnt || bram_rd_addr !== e_addr) begin
                errors++;
                $display("FAIL rnd_arb c=%0d got=%b/%0d exp=%b/%0d", c, gnt, bram_rd_addr, e_gnt, e_addr);
            end
            checks++;
            if (rd_valid !== e_rdv || (e_rdv != 0 && rd_data !== e_rdata)) begin
                errors++;
                $display("FAIL rnd_read c=%0d got=%b/%h exp=%b/%h", c, rd_valid, rd_data, e_rdv, e_rdata);
            end
            checks++;
            if (owner !== 2'(m_owner) || locked !== m_locked || stall_count !== 16'(m_stall)) begin
                errors++;
                $display("FAIL rnd_state c=%0d got=%0d/%b/%0d exp=%0d/%b/%0d", c, owner, locked,
                         stall_count, m_owner, m_locked, m_stall);
            end
            advance();
        end
        req = '0; lock = '0;
        repeat (LAT + 1) begin settle(); advance(); end
    endtask

    task automatic test_stall_saturate();
        req = 3'b010; lock = 3'b010; set_addr(5, 6, 0);
        settle();
        advance();
        req = 3'b011;
        for (int c = 0; c < 70000; c++) begin
            settle();
            advance();
        end
        settle();
        checks++;
        if (stall_count !== 16'hFFFF || stall_count !== 16'(m_stall)) begin
            errors++;
            $display("FAIL sat_count got=%0d exp=65535", stall_count);
        end
        checks++;
        if (gnt !== 3'b010 || locked !== 1'b1) begin
            errors++;
            $display("FAIL sat_lock got=%b/%b exp=010/1", gnt, locked);
        end
        advance();
        lock = '0; req = 3'b001;
        settle();
        checks++;
        if (gnt !== 3'b001 || stall_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_release got=%b/%0d exp=001/65535", gnt, stall_count);
        end
        advance();
        req = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock_burst();
        test_owner_gap();
        test_latency();
        test_reset_midop();
        test_random();
        test_stall_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_read_arbiter.md
Name: bram_read_arbiter

Overview:
- Shares the single BRAM read port (address out, data in) between NUM_REQ requesters, e.g. operation selector, operation executor and a UART matrix dumper.
- Replaces the state-based address mux in the compute subsystem.
- Round-robin arbitration with optional burst lock.
- Per-requester read-valid tracking aligned to fixed BRAM read latency; data is broadcast to all requesters.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_WIDTH, 14, BRAM address width.
- DATA_WIDTH, 32, BRAM data width.
- READ_LATENCY, 1, cycles from address presented to bram_rd_data valid (1..4).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester read request; held with address until granted.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_lock  in  NUM_REQ  while owner holds this high, it keeps the port across cycles.
- gnt  out  NUM_REQ  one-hot grant, same cycle as accepted request.
- rd_valid  out  NUM_REQ  pulses READ_LATENCY cycles after requester's granted read.
- rd_data  out  DATA_WIDTH  pass-through of bram_rd_data.
- bram_rd_addr  out  ADDR_WIDTH  address to BRAM.
- bram_rd_data  in  DATA_WIDTH  BRAM read data.
- owner  out  $clog2(NUM_REQ)  current/last granted index.
- locked  out  1  lock currently held.
- stall_count  out  16  saturating count of cycles with req pending but not granted (any requester).

Behaviour:
- Reset: gnt=0, rd_valid=0, bram_rd_addr=0, owner=0, locked=0, stall_count=0, round-robin pointer=0, latency pipeline cleared.
- Arbitration is combinational within the cycle:
  - Unlocked: winner is the first i with req[i]=1, scanning from pointer upward with wrap at NUM_REQ-1 to 0.
  - gnt[winner]=1; bram_rd_addr = req_addr[winner] combinationally.
  - No req: gnt=0; bram_rd_addr holds last granted address (registered copy).
- Pointer update on a clock edge with a grant and no lock held: pointer <= winner+1, wrapping to 0.
- Lock:
  - If the granted requester has req_lock=1 at the edge, locked<=1 and owner<=winner.
  - While locked, only owner can be granted; others stall even if req=1.
  - Owner with req=0 gets no grant, but lock persists.
  - Release at the first edge where req_lock[owner]=0; that same cycle arbitrates unlocked (owner may win if pointer order permits).
  - Pointer is updated on release to owner+1.
- Read tracking:
  - Shift pipeline of depth READ_LATENCY carries {valid, index} of each grant.
  - rd_valid[index] pulses exactly READ_LATENCY cycles after the grant cycle, one cycle wide.
  - Back-to-back grants to different requesters yield back-to-back rd_valid pulses in grant order.
- rd_data = bram_rd_data (no register).
- stall_count: +1 per cycle where (req & ~gnt) != 0; saturates at 16'hFFFF.
- Requester obligation: keep req and req_addr stable until gnt seen. Arbiter does not latch addresses of ungranted requests.
- Requester index >= NUM_REQ never granted.
- Reset mid-operation: lock dropped, pipeline flushed, so no rd_valid pulses after deassertion for reads issued before reset.
- req_lock asserted without gnt has no effect.

Test Plan:
- NUM_REQ=3, req=3'b111 held 6 cycles, addrs 10/20/30, lock=0 -> gnt sequence 001,010,100,001,010,100. bram_rd_addr 10,20,30,10,20,30. rd_valid mirrors gnt delayed 1 cycle. stall_count=6.
- Req 1 with lock held 4 cycles, addr increments 100..103; req0 asserted from cycle 1 -> gnt[0] stays 0 until cycle after lock drop; addresses 100..103 consecutive; locked=1 throughout.
- Lock owner drops req for 2 cycles mid-burst with req2 pending -> gnt=0 both cycles, bram_rd_addr holds last value, req2 granted only after req_lock[1] falls.
- READ_LATENCY=3, single req0 grant at cycle 5 addr 7 -> rd_valid[0] high exactly at cycle 8, rd_data equals BRAM word at 7.
- rst_n pulled low one cycle after two grants (latency 2) -> no rd_valid pulses, all outputs at reset values, pointer 0 on release.
- Continuous req0 pending under req1 lock for 70000 cycles -> stall_count saturates at 65535.
